// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, hex segment table and scan FSM states
package seg_pkg;

    // All segments dark (active-low encoding {a,b,c,d,e,f,g})
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segment codes indexed by hex value; entry 15 listed first
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - combinational nibble to active-low 7-segment decode
module seg7_hex_lut
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed N-digit 7-segment scanner; SEG_SCAN_DP_EN adds decimal points
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 16,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_blank_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
`ifdef SEG_SCAN_DP_EN
    ,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp
`endif
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    scan_state_e           state_q, state_d;
    logic                  wrap;
    logic [DW-1:0]         staged_q, staged_d, shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic [NUM_DIGITS-1:0] blank_vec, an_sel;
    logic                  lz_run, blank_cur;
    logic [3:0]            nib_cur;
    logic [6:0]            lut_seg;
`ifdef SEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] dp_staged_q, dp_staged_d, dp_shadow_q, dp_shadow_d;
    logic                  dp_q, dp_d, dp_cur;
`endif

    // Prescaler and digit index; FSM state tracks whether the next slot position is in dead time
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        wrap  = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        state_d = (cnt_d < DEAD_END) ? ST_DEAD : ST_SHOW;
    end

    // Scan counters and FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_DEAD;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // Double buffer: staged collects loads, shadow only changes on frame wrap
    always_comb begin
        staged_d  = staged_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
`ifdef SEG_SCAN_DP_EN
        dp_staged_d = dp_staged_q;
        dp_shadow_d = dp_shadow_q;
`endif
        if (load) begin
            staged_d  = data_in;
            pending_d = 1'b1;
`ifdef SEG_SCAN_DP_EN
            dp_staged_d = dp_in;
`endif
        end
        if (wrap && (load || pending_q)) begin
            shadow_d  = load ? data_in : staged_q;
            pending_d = 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_shadow_d = load ? dp_in : dp_staged_q;
`endif
        end
    end

    // Buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staged_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_staged_q <= '0;
            dp_shadow_q <= '0;
`endif
        end else begin
            staged_q  <= staged_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
`ifdef SEG_SCAN_DP_EN
            dp_staged_q <= dp_staged_d;
            dp_shadow_q <= dp_shadow_d;
`endif
        end
    end

    // Per-digit darkness: explicit mask, or all nibbles from this one upward are zero
    always_comb begin
        blank_vec = '0;
        lz_run    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz_run = lz_blank_en && (i != 0);
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (shadow_q[4*j +: 4] != 4'h0) begin
                    lz_run = 1'b0;
                end
            end
            blank_vec[i] = blank_mask[i] | lz_run;
        end
    end

    // Select the current digit's nibble, blank flag and anode pattern
    always_comb begin
        nib_cur   = 4'h0;
        blank_cur = 1'b0;
        an_sel    = AN_OFF;
`ifdef SEG_SCAN_DP_EN
        dp_cur    = 1'b0;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_cur   = shadow_q[4*i +: 4];
                blank_cur = blank_vec[i];
                an_sel[i] = ~AN_OFF[i];
`ifdef SEG_SCAN_DP_EN
                dp_cur    = dp_shadow_q[i];
`endif
            end
        end
    end

    seg7_hex_lut u_lut (
        .nib_i (nib_cur),
        .seg_o (lut_seg)
    );

    // Output next-state: dark during dead time, lit digit otherwise unless blanked
    always_comb begin
        seg_d  = SEG_OFF;
        an_d   = AN_OFF;
        tick_d = wrap;
`ifdef SEG_SCAN_DP_EN
        dp_d   = 1'b1;
`endif
        if (state_q == ST_SHOW) begin
            an_d = an_sel;
            if (!blank_cur) begin
                seg_d = lut_seg;
`ifdef SEG_SCAN_DP_EN
                dp_d  = ~dp_cur;
`endif
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
            tick_q <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_q   <= 1'b1;
`endif
        end else begin
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= tick_d;
`ifdef SEG_SCAN_DP_EN
            dp_q   <= dp_d;
`endif
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
`ifdef SEG_SCAN_DP_EN
    assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic        lz_blank_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  dp_in;
    logic        dp;
`endif

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .DEAD_CYC   (DEAD),
        .AN_ACT_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load        (load),
        .blank_mask  (blank_mask),
        .lz_blank_en (lz_blank_en),
        .seg         (seg),
        .an          (an),
        .frame_tick  (frame_tick)
`ifdef SEG_SCAN_DP_EN
        ,
        .dp_in       (dp_in),
        .dp          (dp)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time since reset release plus frame buffers
    int          t;
    int          last_tick;
    logic [15:0] m_staged, m_shadow;
    bit          m_pending;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_tick;
    logic [7:0]  obs [N];
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  m_dp_staged, m_dp_shadow;
    logic        e_dp;
`endif

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      mask;
        logic            lz;
        logic [3:0][6:0] exp_seg;   // index = digit
    } vec_t;

    task automatic check(input string name, input int tt, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, tt, act, exp);
        end
    endtask

    function automatic logic [6:0] hex_code(input logic [3:0] v);
        case (v)
            4'h0: return 7'h01; 4'h1: return 7'h4F; 4'h2: return 7'h12; 4'h3: return 7'h06;
            4'h4: return 7'h4C; 4'h5: return 7'h24; 4'h6: return 7'h20; 4'h7: return 7'h0F;
            4'h8: return 7'h00; 4'h9: return 7'h04; 4'hA: return 7'h08; 4'hB: return 7'h60;
            4'hC: return 7'h31; 4'hD: return 7'h42; 4'hE: return 7'h30; default: return 7'h38;
        endcase
    endfunction

    function automatic bit ref_dark(input logic [15:0] sh, input int i);
        return blank_mask[i] || (lz_blank_en && i != 0 && (sh >> (4 * i)) == 16'h0);
    endfunction

    task automatic model_edge();
        int  cnt  = t % DIV;
        int  idx  = (t / DIV) % N;
        bit  wrap = (t % FRAME) == FRAME - 1;
        e_tick = wrap;
        if (cnt < DEAD) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
        end else begin
            e_an  = ~(4'b0001 << idx);
            e_seg = ref_dark(m_shadow, idx) ? 7'h7F : hex_code(4'(m_shadow >> (4 * idx)));
        end
`ifdef SEG_SCAN_DP_EN
        e_dp = (cnt < DEAD || ref_dark(m_shadow, idx)) ? 1'b1 : ~m_dp_shadow[idx];
`endif
        if (load) begin
            m_staged  = data_in;
            m_pending = 1'b1;
`ifdef SEG_SCAN_DP_EN
            m_dp_staged = dp_in;
`endif
        end
        if (wrap && m_pending) begin
            m_shadow  = m_staged;
            m_pending = 1'b0;
`ifdef SEG_SCAN_DP_EN
            m_dp_shadow = m_dp_staged;
`endif
        end
        t++;
    endtask

    task automatic step();
        int tt;
        @(posedge clk);
        tt = t;
        model_edge();
        #1;
        check("seg", tt, 32'(seg), 32'(e_seg));
        check("an", tt, 32'(an), 32'(e_an));
        check("tick", tt, 32'(frame_tick), 32'(e_tick));
`ifdef SEG_SCAN_DP_EN
        check("dp", tt, 32'(dp), 32'(e_dp));
`endif
        if (frame_tick) begin
            if (last_tick >= 0) check("tick_gap", tt, 32'(tt - last_tick), 32'(FRAME));
            last_tick = tt;
        end
        for (int i = 0; i < N; i++) begin
            if (an == ~(4'b0001 << i)) obs[i] = {1'b0, seg};
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        data_in = d;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < N; i++) obs[i] = 8'hFF;
    endtask

    task automatic to_phase(input int ph);
        for (int k = 0; k < FRAME && (t % FRAME) != ph; k++) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg"}, t, 32'(seg), 32'h7F);
        check({tag, "_an"}, t, 32'(an), 32'hF);
        check({tag, "_tick"}, t, 32'(frame_tick), 32'h0);
`ifdef SEG_SCAN_DP_EN
        check({tag, "_dp"}, t, 32'(dp), 32'h1);
`endif
    endtask

    // Assert reset a few time units into a cycle, check, then release on the falling edge
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3 rst = 1'b1;
        load = 1'b0;
        #1 check_reset_vals(tag);
        @(negedge clk);
        rst       = 1'b0;
        t         = 0;
        last_tick = -1;
        m_staged  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
`ifdef SEG_SCAN_DP_EN
        m_dp_staged = '0;
        m_dp_shadow = '0;
`endif
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}};
        vecs[1] = '{16'hABCD, 4'b0000, 1'b0, {7'h08, 7'h60, 7'h31, 7'h42}};
        vecs[2] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h0F, 7'h01}};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[4] = '{16'h8888, 4'b0010, 1'b0, {7'h00, 7'h00, 7'h7F, 7'h00}};
        vecs[5] = '{16'h0070, 4'b0000, 1'b0, {7'h01, 7'h01, 7'h0F, 7'h01}};
        vecs[6] = '{16'h0509, 4'b0000, 1'b1, {7'h7F, 7'h24, 7'h01, 7'h04}};
        vecs[7] = '{16'hF00E, 4'b1000, 1'b1, {7'h7F, 7'h01, 7'h01, 7'h30}};

        rst = 1'b0; load = 1'b0; data_in = '0; blank_mask = '0; lz_blank_en = 1'b0;
`ifdef SEG_SCAN_DP_EN
        dp_in = 4'b0100;
`endif
        clear_obs();
        #2 rst = 1'b1;
        #3 check_reset_vals("init_rst");
        pulse_reset("rst0");

        // Table-driven display vectors
        for (int v = 0; v < 8; v++) begin
            blank_mask  = vecs[v].mask;
            lz_blank_en = vecs[v].lz;
            do_load(vecs[v].data);
            to_phase(0);
            clear_obs();
            for (int k = 0; k < FRAME; k++) step();
            for (int i = 0; i < N; i++)
                check($sformatf("vec%0d_d%0d", v, i), t, 32'(obs[i]), 32'(vecs[v].exp_seg[i]));
        end
        blank_mask  = '0;
        lz_blank_en = 1'b0;

        // Mid-frame load does not tear the current frame
        do_load(16'h1234);
        to_phase(0);
        for (int k = 0; k < FRAME; k++) step();
        to_phase(8);
        do_load(16'hABCD);
        clear_obs();
        to_phase(0);
        check("midload_d1", t, 32'(obs[1]), 32'h06);
        check("midload_d2", t, 32'(obs[2]), 32'h12);
        check("midload_d3", t, 32'(obs[3]), 32'h4F);
        clear_obs();
        for (int k = 0; k < FRAME; k++) step();
        check("nextframe_d0", t, 32'(obs[0]), 32'h42);
        check("nextframe_d3", t, 32'(obs[3]), 32'h08);

        // Load landing on the wrap cycle shows in the frame that starts there
        to_phase(FRAME - 1);
        do_load(16'h5678);
        clear_obs();
        for (int k = 0; k < FRAME; k++) step();
        check("wrapload_d0", t, 32'(obs[0]), 32'h00);
        check("wrapload_d3", t, 32'(obs[3]), 32'h24);

        // Reset mid-slot discards staged data
        to_phase(13);
        do_load(16'h9999);
        pulse_reset("rst_mid");
        clear_obs();
        for (int k = 0; k < 2 * FRAME; k++) step();
        check("post_rst_d2", t, 32'(obs[2]), 32'h01);

        // Randomized traffic against the model, with one reset in the middle
        for (int k = 0; k < 1200; k++) begin
            if (k == 600) pulse_reset("rst_rand");
            load    = ($urandom_range(0, 9) == 0);
            data_in = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
`ifdef SEG_SCAN_DP_EN
            dp_in   = 4'($urandom);
`endif
            if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lz_blank_en = 1'($urandom_range(0, 1));
            step();
            load = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
